spi_bus_arbiter: RTL
====================

Name: spi_bus_arbiter

Overview:
- Shares the single SPI master Wishbone slave port between two Wishbone requesters: m0 is the CPU and m1 is the SD/boot DMA engine.
- Grants are round-robin per bus cycle.
- Ownership is locked for the whole chip-select transaction. It starts when the owner writes the selects byte (adr 1) to a value other than 8'hff and ends when it writes 8'hff back.
- Sits between the system interconnect and the SPI master.

Parameters:
- TIMEOUT, 1000000, idle clock cycles allowed while locked before a forced release. Used only with SPI_ARB_TIMEOUT_EN.
- TCW, 32, width of the timeout counter.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  requester 0 bus cycle / strobe / write
- m0_adr_i  in  1  requester 0 register address
- m0_sel_i  in  4  requester 0 byte selects
- m0_dat_i  in  32  requester 0 write data
- m0_dat_o  out  32  read data to requester 0
- m0_ack_o  out  1  ack to requester 0
- m1_*  same set as m0_*  requester 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to SPI master
- s_adr_o  out  1  to SPI master
- s_sel_o  out  4  to SPI master
- s_dat_o  out  32  to SPI master
- s_dat_i  in  32  read data from SPI master
- s_ack_i  in  1  ack from SPI master
- grant_o  out  2  one-hot current owner; 00 when idle
- locked_o  out  1  chip-select lock held
- timeout_o  out  1  one-cycle pulse on forced release

Behaviour:
- Reset: rst_i asynchronous, active-high; clock clk_i.
  - Reset values: state IDLE, grant_o 00, locked_o 0, timeout_o 0, last-owner pointer = 1 (so m0 wins the first tie), counter 0.
  - All s_* outputs and m*_ack_o are 0; m*_dat_o are 0.
- States: IDLE, GNT0, GNT1, plus FORCE (macro only).
- IDLE:
  - m0_cyc_i only -> GNT0 next cycle.
  - m1_cyc_i only -> GNT1 next cycle.
  - Both -> grant the requester that is not the last owner.
  - Arbitration latency is 1 cycle: a request in cycle N drives the s_* outputs from cycle N+1.
- GNTx: s_cyc/stb/we/adr/sel/dat_o are combinationally muxed from mx.
  - mx_ack_o = s_ack_i.
  - The non-owner's ack is forced to 0, so it stalls with cyc held.
  - Both m*_dat_o = s_dat_i, qualified only by ack.
- Lock update on s_ack_i while s_we_o=1, s_adr_o=1 and s_sel_o[3]=1:
  - s_dat_o[31:24] != 8'hff -> locked_o=1 from the next cycle.
  - s_dat_o[31:24] == 8'hff -> locked_o=0 from the next cycle.
  - Other writes and reads leave the lock unchanged.
- Release: in GNTx with mx_cyc_i=0 and lock clear (after any same-cycle lock update) -> IDLE next cycle, last-owner pointer = x.
  - Locked: stay in GNTx regardless of the owner's cyc.
  - Owner drops cyc and the other requester is waiting: IDLE for one cycle, then the other requester is granted. Maximum 2-cycle turnaround.
- Bus cycle safety: the grant never changes while the owner's cyc is high. The arbiter does not generate stb on its own except in FORCE.
- Mid-cycle reset: abandons any slave cycle. The SPI master is reset by the same rst_i.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Counter behaviour (with macro):
  - Counter clears on any owner ack and whenever unlocked.
  - Increments while locked and the owner's cyc_i=0.
  - Frozen while the owner's cyc_i=1.
- Forced release (with macro): counter == TIMEOUT-1 with owner cyc low -> FORCE.
  - FORCE drives s_cyc=s_stb=1, we=1, adr=1, sel=4'b1000, dat=32'hff000000, and holds until s_ack_i.
  - Both m*_ack_o are 0 during FORCE.
  - On s_ack_i: locked_o clears, timeout_o pulses for 1 cycle, state -> IDLE, pointer = old owner.
- Without the macro: no counter and no FORCE state; the lock is held indefinitely; timeout_o is tied to 0.

Test Plan:
- Single requester read: m0 reads adr 0, SPI returns 8'h5a. Required: grant_o=01 one cycle after cyc, m0_ack_o pulses once with m0_dat_o[7:0]=8'h5a, m1_ack_o stays 0.
- Simultaneous requests from reset: m0 and m1 raise cyc in the same cycle. Required: m0 granted first; after m0 drops cyc, grant_o=10 within 2 cycles; on the next tie m0 wins again.
- Lock: m1 writes adr1 sel 4'b1000 dat 32'hfe000000, drops cyc, then m0 requests. Required: locked_o=1, grant_o stays 10, m0 stalls. m1 then writes 32'hff000000. Required: lock clears and m0 is granted within 2 cycles.
- Non-select write: owner writes adr1 sel 4'b0100 dat 32'h00030000 (conf only). Required: locked_o unchanged.
- Timeout (macro on, TIMEOUT=16): m0 locks, then idles. Required: after 16 idle cycles the slave sees a write of 32'hff000000 to adr1 sel 4'b1000; timeout_o pulses; locked_o=0; a waiting m1 is granted.
- Reset during a locked GNT1 with m0 waiting. Required: grant_o=00 and locked_o=0 immediately; after reset, m0 is granted if it requests.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares the SPI master Wishbone slave port between m0 (CPU) and m1 (SD/boot DMA).
// Latency: grant one cycle after cyc; address/data/ack paths are combinational while granted.
// Backpressure: the non-owner gets no ack and stalls with cyc held; a chip-select lock pins the grant.
// Optional: define SPI_ARB_TIMEOUT_EN to force-release a lock left idle for TIMEOUT cycles.
module spi_bus_arbiter #(
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned TCW     = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic        m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic        m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic        s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        locked_o,
  output logic        timeout_o
);

`ifdef SPI_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, FORCE = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;
`endif

  state_e state_q, state_d;
  logic   last_q, last_d;      // 1: m1 was the last owner, so m0 wins the next tie
  logic   locked_q, locked_d;
  logic   in_gnt;
  logic   own_cyc;
  logic   own_ack;
  logic   cs_wr;

  assign in_gnt  = (state_q == GNT0) || (state_q == GNT1);
  assign own_cyc = (state_q == GNT1) ? m1_cyc_i : m0_cyc_i;
  assign own_ack = in_gnt && s_ack_i;
  // A completed write to the selects byte decides the chip-select lock.
  assign cs_wr   = own_ack && s_we_o && s_adr_o && s_sel_o[3];

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TCW-1:0] cnt_q, cnt_d;
  logic           timeout_q, timeout_d;
  logic           cnt_hit;

  assign cnt_hit   = (cnt_q == TCW'(TIMEOUT - 1));
  assign timeout_o = timeout_q;

  // Idle-lock timer: counts only while a locked owner holds cyc low.
  always_comb begin
    cnt_d = cnt_q;
    if (!locked_q || !in_gnt || own_ack) begin
      cnt_d = '0;
    end else if (!own_cyc) begin
      cnt_d = cnt_q + TCW'(1);
    end
  end

  // Timer and release-pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  // No forced release in this build; the lock lasts until the owner frees it.
  localparam bit TimeoutCfg = (TIMEOUT > 0) && (TCW > 0);
  assign timeout_o = 1'b0 && TimeoutCfg;
`endif

  // Slave-side mux: the owner drives the SPI master; the non-owner sees no ack.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = 1'b0;
    s_sel_o  = 4'h0;
    s_dat_o  = 32'h0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state_q)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
      end
`ifdef SPI_ARB_TIMEOUT_EN
      FORCE: begin
        // Arbiter-owned write deasserting every chip select.
        s_cyc_o = 1'b1;
        s_stb_o = 1'b1;
        s_we_o  = 1'b1;
        s_adr_o = 1'b1;
        s_sel_o = 4'b1000;
        s_dat_o = 32'hff00_0000;
      end
`endif
      default: ;
    endcase
  end

  // Read data is broadcast; each requester qualifies it with its own ack.
  assign m0_dat_o = s_ack_i ? s_dat_i : 32'h0;
  assign m1_dat_o = s_ack_i ? s_dat_i : 32'h0;

  // One-hot owner indication; during a forced release the old owner still holds the lock.
  always_comb begin
    grant_o = 2'b00;
    case (state_q)
      GNT0:    grant_o = 2'b01;
      GNT1:    grant_o = 2'b10;
`ifdef SPI_ARB_TIMEOUT_EN
      FORCE:   grant_o = last_q ? 2'b10 : 2'b01;
`endif
      default: grant_o = 2'b00;
    endcase
  end

  assign locked_o = locked_q;

  // Next state: round-robin grant from IDLE, hold while cyc or lock, release to IDLE.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    locked_d = locked_q;
`ifdef SPI_ARB_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    if (cs_wr) begin
      locked_d = (s_dat_o[31:24] != 8'hff);
    end
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!own_cyc && !locked_d) begin
          state_d = IDLE;
          last_d  = (state_q == GNT1);
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (!own_cyc && cnt_hit) begin
          state_d = FORCE;
          last_d  = (state_q == GNT1);
        end
`endif
      end
`ifdef SPI_ARB_TIMEOUT_EN
      FORCE: begin
        if (s_ack_i) begin
          state_d   = IDLE;
          locked_d  = 1'b0;
          timeout_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, owner pointer and lock registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      locked_q <= locked_d;
    end
  end

endmodule
